// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//   Fetch-side program-counter controller. Advances the PC by the number of
//   valid lanes in the current fetch bundle. Holds while the back end is full,
//   and redirects to a new target on a branch mispredict flush. After a
//   redirect it inserts a fixed number of bubble cycles.
//
//   Optional build macro: PC_FETCH_PERF_CNT_EN
//     defined   -> saturating stall/flush performance counters are built
//     undefined -> stall_cnt and flush_cnt are tied to zero (no registers)
//
// Parameters
//   PC_W         PC width in bits
//   FETCH_W      fetch lanes per cycle (1..4)
//   RESET_PC     PC value loaded at reset
//   REDIRECT_CYC bubble cycles after a flush (1..7)
//   CNT_W        performance counter width
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   vld          per-lane valid of the current fetch bundle
//   iq_full      issue queue full
//   buffer_full  reorder buffer full
//   bid_full     branch ids exhausted
//   flush        redirect request (highest priority)
//   flush_addr   redirect target
//   pc           registered fetch PC
//   fetch_en     registered, high only while in RUN
//   state        IDLE=0, RUN=1, STALL=2, REDIRECT=3
//   stall_cnt    cycles spent in STALL (saturating)
//   flush_cnt    accepted flushes (saturating)
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int PC_W         = 5,
  parameter int FETCH_W      = 2,
  parameter int RESET_PC     = 0,
  parameter int REDIRECT_CYC = 1,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FETCH_W-1:0] vld,
  input  logic               iq_full,
  input  logic               buffer_full,
  input  logic               bid_full,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_addr,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_en,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STALL    = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_en;
  logic [2:0]      r_bub;

  logic [1:0]      w_state_next;
  logic [PC_W-1:0] w_pc_next;
  logic [2:0]      w_bub_next;
  logic            w_fetch_en_next;
  logic            w_stall;
  logic [PC_W-1:0] w_pop;
  logic [PC_W-1:0] w_lane_inc [FETCH_W];

  assign w_stall = iq_full | buffer_full | bid_full;

  // Per-lane increment, widened to PC width so the sum wraps modulo 2^PC_W.
  genvar gi;
  generate
    for (gi = 0; gi < FETCH_W; gi++) begin : g_lane
      assign w_lane_inc[gi] = PC_W'(vld[gi]);
    end
  endgenerate

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      w_pop = w_pop + w_lane_inc[i];
    end
  end

  // State register (plus the datapath registers that follow it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= PC_W'(RESET_PC);
      r_fetch_en <= 1'b0;
      r_bub      <= 3'd0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_fetch_en <= w_fetch_en_next;
      r_bub      <= w_bub_next;
    end
  end

  // Next-state logic. A flush overrides everything, including a flush that
  // arrives while a previous redirect is still draining its bubbles.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_bub_next   = r_bub;
    if (flush) begin
      w_state_next = ST_REDIRECT;
      w_pc_next    = flush_addr;
      w_bub_next   = 3'(REDIRECT_CYC);
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next = w_stall ? ST_STALL : ST_RUN;
        end
        ST_RUN: begin
          if (w_stall) begin
            w_state_next = ST_STALL;
          end else begin
            w_pc_next = r_pc + w_pop;
          end
        end
        ST_STALL: begin
          if (!w_stall) begin
            w_state_next = ST_RUN;
          end
        end
        default: begin
          // The counter holds the number of REDIRECT cycles still to spend,
          // this one included; a value of 1 (or less) means this is the last.
          if (r_bub <= 3'd1) begin
            w_bub_next   = 3'd0;
            w_state_next = w_stall ? ST_STALL : ST_RUN;
          end else begin
            w_bub_next = r_bub - 3'd1;
          end
        end
      endcase
    end
  end

  // Output logic: fetch_en is registered, so it is derived from the next state.
  always_comb begin
    w_fetch_en_next = (w_state_next == ST_RUN);
  end

  assign pc       = r_pc;
  assign fetch_en = r_fetch_en;
  assign state    = r_state;

`ifdef PC_FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((r_state == ST_STALL) && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Directed self-checking bench for pc_fetch_ctrl (PC_W=5, FETCH_W=2,
//   REDIRECT_CYC=2). Expected counter values follow PC_FETCH_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam int PC_W  = 5;
  localparam int FW    = 2;
  localparam int CNT_W = 16;
`ifdef PC_FETCH_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [FW-1:0]    vld = '0;
  logic             iq_full = 1'b0;
  logic             buffer_full = 1'b0;
  logic             bid_full = 1'b0;
  logic             flush = 1'b0;
  logic [PC_W-1:0]  flush_addr = '0;
  logic [PC_W-1:0]  pc;
  logic             fetch_en;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks   = 0;
  int failures = 0;

  pc_fetch_ctrl #(
    .PC_W(PC_W), .FETCH_W(FW), .RESET_PC(0), .REDIRECT_CYC(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .vld(vld), .iq_full(iq_full),
    .buffer_full(buffer_full), .bid_full(bid_full), .flush(flush),
    .flush_addr(flush_addr), .pc(pc), .fetch_en(fetch_en), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL reset_pc actual=%0d expected=0", pc); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state actual=%0d expected=0", state); end
    checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL reset_fetch_en actual=%0b expected=0", fetch_en); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt actual=%0d expected=0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_flush_cnt actual=%0d expected=0", flush_cnt); end
    tick(); tick();
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_hold_state actual=%0d expected=0", state); end
    $display("test_reset done");
  endtask

  task automatic test_run();
    @(negedge clk);
    rst = 1'b1; vld = 2'b11;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL run_idle_state actual=%0d expected=0", state); end
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL run_enter_state actual=%0d expected=1", state); end
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL run_enter_pc actual=%0d expected=0", pc); end
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL run_fetch_en actual=%0b expected=1", fetch_en); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (pc !== 5'(2 * k)) begin failures++; $display("FAIL run_pc step=%0d actual=%0d expected=%0d", k, pc, 2 * k); end
    end
    $display("test_run done pc=%0d", pc);
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++; if (pc !== 5'(6 + 2 * i)) begin failures++; $display("FAIL wrap_climb step=%0d actual=%0d expected=%0d", i, pc, 6 + 2 * i); end
    end
    tick();
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL wrap_pc actual=%0d expected=0", pc); end
    vld = 2'b01;
    tick();
    checks++; if (pc !== 5'd1) begin failures++; $display("FAIL wrap_one_lane actual=%0d expected=1", pc); end
    vld = 2'b00;
    tick();
    checks++; if (pc !== 5'd1) begin failures++; $display("FAIL zero_vld_pc actual=%0d expected=1", pc); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL zero_vld_state actual=%0d expected=1", state); end
    vld = 2'b10;
    tick();
    checks++; if (pc !== 5'd2) begin failures++; $display("FAIL lane1_pc actual=%0d expected=2", pc); end
    vld = 2'b11;
    tick(); tick(); tick();
    checks++; if (pc !== 5'd8) begin failures++; $display("FAIL to8_pc actual=%0d expected=8", pc); end
    $display("test_wrap done pc=%0d", pc);
  endtask

  task automatic test_stall();
    iq_full = 1'b1;
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL stall_state actual=%0d expected=2", state); end
    checks++; if (pc !== 5'd8) begin failures++; $display("FAIL stall_pc actual=%0d expected=8", pc); end
    checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL stall_fetch_en actual=%0b expected=0", fetch_en); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stall_cnt_first actual=%0d expected=0", stall_cnt); end
    tick(); tick();
    checks++; if (pc !== 5'd8) begin failures++; $display("FAIL stall_hold_pc actual=%0d expected=8", pc); end
    checks++; if (stall_cnt !== 16'(2 * PERF)) begin failures++; $display("FAIL stall_cnt_mid actual=%0d expected=%0d", stall_cnt, 2 * PERF); end
    iq_full = 1'b0;
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL stall_resume_state actual=%0d expected=1", state); end
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL stall_resume_fetch_en actual=%0b expected=1", fetch_en); end
    checks++; if (pc !== 5'd8) begin failures++; $display("FAIL stall_resume_pc actual=%0d expected=8", pc); end
    checks++; if (stall_cnt !== 16'(3 * PERF)) begin failures++; $display("FAIL stall_cnt actual=%0d expected=%0d", stall_cnt, 3 * PERF); end
    tick();
    checks++; if (pc !== 5'd10) begin failures++; $display("FAIL stall_after_pc actual=%0d expected=10", pc); end
    bid_full = 1'b1;
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL bid_stall_state actual=%0d expected=2", state); end
    bid_full = 1'b0;
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL bid_resume_state actual=%0d expected=1", state); end
    checks++; if (pc !== 5'd10) begin failures++; $display("FAIL bid_pc actual=%0d expected=10", pc); end
    checks++; if (stall_cnt !== 16'(4 * PERF)) begin failures++; $display("FAIL bid_stall_cnt actual=%0d expected=%0d", stall_cnt, 4 * PERF); end
    $display("test_stall done pc=%0d", pc);
  endtask

  task automatic test_flush();
    flush = 1'b1; flush_addr = 5'd17; buffer_full = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL flush_state actual=%0d expected=3", state); end
    checks++; if (pc !== 5'd17) begin failures++; $display("FAIL flush_pc actual=%0d expected=17", pc); end
    checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL flush_fetch_en actual=%0b expected=0", fetch_en); end
    checks++; if (flush_cnt !== 16'(PERF)) begin failures++; $display("FAIL flush_cnt actual=%0d expected=%0d", flush_cnt, PERF); end
    tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL flush_bubble2_state actual=%0d expected=3", state); end
    tick();
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL flush_to_stall_state actual=%0d expected=2", state); end
    checks++; if (pc !== 5'd17) begin failures++; $display("FAIL flush_stall_pc actual=%0d expected=17", pc); end
    checks++; if (stall_cnt !== 16'(4 * PERF)) begin failures++; $display("FAIL flush_stall_cnt actual=%0d expected=%0d", stall_cnt, 4 * PERF); end
    buffer_full = 1'b0;
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL flush_resume_state actual=%0d expected=1", state); end
    checks++; if (stall_cnt !== 16'(5 * PERF)) begin failures++; $display("FAIL flush_resume_stall_cnt actual=%0d expected=%0d", stall_cnt, 5 * PERF); end
    tick();
    checks++; if (pc !== 5'd19) begin failures++; $display("FAIL flush_resume_pc actual=%0d expected=19", pc); end
    $display("test_flush done pc=%0d", pc);
  endtask

  task automatic test_reset_mid_redirect();
    flush = 1'b1; flush_addr = 5'd20;
    tick();
    flush = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL mid_pre_state actual=%0d expected=3", state); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL async_pc actual=%0d expected=0", pc); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL async_state actual=%0d expected=0", state); end
    checks++; if (fetch_en !== 1'b0) begin failures++; $display("FAIL async_fetch_en actual=%0b expected=0", fetch_en); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL async_stall_cnt actual=%0d expected=0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin failures++; $display("FAIL async_flush_cnt actual=%0d expected=0", flush_cnt); end
    tick();
    @(negedge clk);
    rst = 1'b1; vld = 2'b00;
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL post_reset_state actual=%0d expected=1", state); end
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL post_reset_pc actual=%0d expected=0", pc); end
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL no_redirect_state actual=%0d expected=1", state); end
    checks++; if (pc !== 5'd0) begin failures++; $display("FAIL no_redirect_pc actual=%0d expected=0", pc); end
    $display("test_reset_mid_redirect done");
  endtask

  task automatic test_back_to_back();
    vld = 2'b11; flush = 1'b1; flush_addr = 5'd17;
    tick();
    checks++; if (pc !== 5'd17) begin failures++; $display("FAIL b2b_first_pc actual=%0d expected=17", pc); end
    checks++; if (flush_cnt !== 16'(PERF)) begin failures++; $display("FAIL b2b_first_cnt actual=%0d expected=%0d", flush_cnt, PERF); end
    flush_addr = 5'd5;
    tick();
    flush = 1'b0;
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL b2b_state actual=%0d expected=3", state); end
    checks++; if (pc !== 5'd5) begin failures++; $display("FAIL b2b_pc actual=%0d expected=5", pc); end
    checks++; if (flush_cnt !== 16'(2 * PERF)) begin failures++; $display("FAIL b2b_flush_cnt actual=%0d expected=%0d", flush_cnt, 2 * PERF); end
    tick();
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL b2b_bubble2_state actual=%0d expected=3", state); end
    checks++; if (pc !== 5'd5) begin failures++; $display("FAIL b2b_bubble2_pc actual=%0d expected=5", pc); end
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL b2b_run_state actual=%0d expected=1", state); end
    checks++; if (fetch_en !== 1'b1) begin failures++; $display("FAIL b2b_fetch_en actual=%0b expected=1", fetch_en); end
    checks++; if (pc !== 5'd5) begin failures++; $display("FAIL b2b_run_pc actual=%0d expected=5", pc); end
    tick();
    checks++; if (pc !== 5'd7) begin failures++; $display("FAIL b2b_adv_pc actual=%0d expected=7", pc); end
    $display("test_back_to_back done pc=%0d", pc);
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_stall();
    test_flush();
    test_reset_mid_redirect();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
